csa_multi_accumulator: RTL and testbench

Streaming multi-operand adder that replaces the fixed four-operand, 4-bit carry-save adder with a parametrised, pipelined block. Each accepted beat carries NUM_OPS operands of WIDTH bits. Operands are folded into a running sum/carry pair by a 3:2 carry-save tree, so an unbounded sequence of beats costs no carry propagation. A single carry-propagate add resolves the result when the packet's last beat arrives. The block sits between operand producers (DSP/datapath front-end) and any consumer using valid/ready handshakes.

---
 rtl/csa_multi_accumulator.sv | 163 ++++++++++++++++
 tb/tb_csa_multi_accumulator.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_multi_accumulator.sv
// ---------------------------------------------------------------------------
// csa_multi_accumulator
//
// Streaming multi-operand adder. Each accepted beat carries NUM_OPS unsigned
// operands of WIDTH bits. The operands are folded into a redundant sum/carry
// pair (acc_s/acc_c) through 3:2 carry-save compressors, so accumulating any
// number of beats needs no carry propagation. One carry-propagate add
// resolves the packet when its last beat has been taken, in a single
// RESOLVE cycle.
//
// Parameters
//   WIDTH      operand width in bits (>= 2)
//   NUM_OPS    operands per beat (>= 2)
//   MAX_BEATS  beats per packet that are guaranteed not to wrap (>= 1)
//   SUM_W      result width, WIDTH + clog2(NUM_OPS*MAX_BEATS)
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   in_valid      beat offered by the producer
//   in_ready      beat taken when in_valid && in_ready; driven from state only
//   in_last       marks the final beat of a packet
//   in_data       operand k at in_data[k*WIDTH +: WIDTH]
//   out_valid     result held in the output register
//   out_ready     consumer takes the result when out_valid && out_ready
//   out_sum       packet sum mod 2^SUM_W
//   out_overflow  packet had more than MAX_BEATS beats (sum may have wrapped)
// ---------------------------------------------------------------------------
module csa_multi_accumulator #(
  parameter  int WIDTH     = 4,
  parameter  int NUM_OPS   = 4,
  parameter  int MAX_BEATS = 4,
  localparam int SUM_W     = WIDTH + $clog2(NUM_OPS * MAX_BEATS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_last,
  input  logic [NUM_OPS*WIDTH-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SUM_W-1:0]         out_sum,
  output logic                     out_overflow
);

  // The counter must be able to hold MAX_BEATS+1 (its saturation value).
  localparam int CNT_W = $clog2(MAX_BEATS + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_BEATS + 1);

  typedef enum logic {
    ACCUM   = 1'b0,
    RESOLVE = 1'b1
  } state_e;

  state_e            state_q,      state_d;
  logic [SUM_W-1:0]  acc_s_q,      acc_s_d;
  logic [SUM_W-1:0]  acc_c_q,      acc_c_d;
  logic [CNT_W-1:0]  beat_cnt_q,   beat_cnt_d;
  logic              ovf_flag_q,   ovf_flag_d;
  logic              out_valid_q,  out_valid_d;
  logic [SUM_W-1:0]  out_sum_q,    out_sum_d;
  logic              out_ovf_q,    out_ovf_d;

  logic [SUM_W-1:0]  tree_s, tree_c;
  logic [SUM_W-1:0]  csa_op, csa_sum, csa_car;

  // -------------------------------------------------------------------------
  // Carry-save reduction: acc_s, acc_c and the NUM_OPS zero-extended operands
  // pass through a chain of 3:2 compressors, each absorbing one operand.
  // The carry vector is shifted left by one and truncated to SUM_W, which
  // keeps the redundant pair congruent to the true sum mod 2^SUM_W.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written here gets a value before any branch or
    // loop, so no path can leave it unassigned and infer a latch.
    tree_s  = acc_s_q;
    tree_c  = acc_c_q;
    csa_op  = '0;
    csa_sum = '0;
    csa_car = '0;
    for (int k = 0; k < NUM_OPS; k++) begin
      csa_op  = SUM_W'(in_data[k*WIDTH +: WIDTH]);
      csa_sum = tree_s ^ tree_c ^ csa_op;
      csa_car = ((tree_s & tree_c) | (tree_s & csa_op) | (tree_c & csa_op)) << 1;
      tree_s  = csa_sum;
      tree_c  = csa_car;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic: FSM, accumulator, beat counter and output register.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    acc_s_d     = acc_s_q;
    acc_c_d     = acc_c_q;
    beat_cnt_d  = beat_cnt_q;
    ovf_flag_d  = ovf_flag_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;
    // A drained result clears unless a new one is loaded below.
    out_valid_d = out_valid_q && !out_ready;

    unique case (state_q)
      ACCUM: begin
        if (in_valid) begin
          acc_s_d = tree_s;
          acc_c_d = tree_c;
          if (beat_cnt_q != CNT_SAT) beat_cnt_d = beat_cnt_q + 1'b1;
          // This beat pushes the count past MAX_BEATS.
          if (beat_cnt_q >= CNT_MAX) ovf_flag_d = 1'b1;
          if (in_last) state_d = RESOLVE;
        end
      end
      RESOLVE: begin
        // Load when the slot is empty or its current result leaves this edge.
        if (!out_valid_q || out_ready) begin
          out_sum_d   = acc_s_q + acc_c_q;
          out_ovf_d   = ovf_flag_q;
          out_valid_d = 1'b1;
          acc_s_d     = '0;
          acc_c_d     = '0;
          beat_cnt_d  = '0;
          ovf_flag_d  = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_s_q     <= '0;
      acc_c_q     <= '0;
      beat_cnt_q  <= '0;
      ovf_flag_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the
      // values present before the edge, independent of statement order.
      state_q     <= state_d;
      acc_s_q     <= acc_s_d;
      acc_c_q     <= acc_c_d;
      beat_cnt_q  <= beat_cnt_d;
      ovf_flag_q  <= ovf_flag_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign in_ready     = (state_q == ACCUM);
  assign out_valid    = out_valid_q;
  assign out_sum      = out_sum_q;
  assign out_overflow = out_ovf_q;

endmodule

// File: tb/tb_csa_multi_accumulator.sv
// ---------------------------------------------------------------------------
// tb_csa_multi_accumulator
//
// Directed scenarios plus a randomized back-to-back stream for
// csa_multi_accumulator with WIDTH=4, NUM_OPS=4, MAX_BEATS=4 (SUM_W=8).
// Inputs change on the falling edge; outputs are sampled on the falling edge
// (or shortly after it), well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_csa_multi_accumulator;

  localparam int W  = 4;
  localparam int N  = 4;
  localparam int MB = 4;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic [N*W-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_sum;
  logic          out_overflow;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    int sum;
    bit ovf;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  bit   mon_en   = 1'b0;
  bit   drv_done = 1'b0;

  csa_multi_accumulator #(.WIDTH(W), .NUM_OPS(N), .MAX_BEATS(MB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_last      (in_last),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_overflow (out_overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [N*W-1:0] pk(int a, int b, int c, int d);
    return {4'(d), 4'(c), 4'(b), 4'(a)};
  endfunction

  // Offer one beat and hold it until the DUT takes it. Called at a falling
  // edge; returns at the falling edge right after the accepting rising edge.
  task automatic drive_beat(input logic [N*W-1:0] data, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drive_beat_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Scoreboard for the random stream: checks each handshake that the next
  // rising edge will complete.
  always @(negedge clk) begin
    if (mon_en) begin
      #3;
      if (out_valid && out_ready) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL stream_extra: unexpected result out_sum=%0d, required no result", out_sum);
        end else begin
          mon_e = exp_q.pop_front();
          if (out_sum !== 8'(mon_e.sum) || out_overflow !== mon_e.ovf) begin
            tests_failed++;
            $display("FAIL stream_result: out_sum=%0d out_overflow=%0b, required %0d/%0b",
                     out_sum, out_overflow, 8'(mon_e.sum), mon_e.ovf);
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_sum !== 8'd0 || out_overflow !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_state: valid=%0b sum=%0d ovf=%0b ready=%0b, required 0/0/0/1",
               out_valid, out_sum, out_overflow, in_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release: valid=%0b ready=%0b, required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_single_beat();
    logic [N*W-1:0] d [4];
    int             e [4];
    d[0] = pk(10, 0, 0, 0);   e[0] = 10;
    d[1] = pk(10, 10, 0, 0);  e[1] = 20;
    d[2] = pk(4, 6, 12, 0);   e[2] = 22;
    d[3] = pk(15, 15, 15, 15); e[3] = 60;
    for (int i = 0; i < 4; i++) begin
      drive_beat(d[i], 1'b1);
      tests_run++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL single_resolve[%0d]: ready=%0b valid=%0b, required 0/0", i, in_ready, out_valid);
      end
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b1 || out_sum !== 8'(e[i]) || out_overflow !== 1'b0) begin
        tests_failed++;
        $display("FAIL single_sum[%0d]: valid=%0b sum=%0d ovf=%0b, required 1/%0d/0",
                 i, out_valid, out_sum, out_overflow, e[i]);
      end
    end
  endtask

  task automatic test_two_beat();
    drive_beat(pk(11, 2, 4, 7), 1'b0);
    drive_beat(pk(12, 5, 10, 10), 1'b1);
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL two_beat_ready_low: in_ready=%0b, required 0", in_ready);
    end
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_sum !== 8'd61 || out_overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL two_beat_sum: ready=%0b valid=%0b sum=%0d ovf=%0b, required 1/1/61/0",
               in_ready, out_valid, out_sum, out_overflow);
    end
  endtask

  task automatic test_max_packet();
    for (int b = 0; b < 4; b++) drive_beat(pk(15, 15, 15, 15), logic'(b == 3));
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b1 || out_sum !== 8'd240 || out_overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL max_packet: valid=%0b sum=%0d ovf=%0b, required 1/240/0",
               out_valid, out_sum, out_overflow);
    end
    for (int b = 0; b < 5; b++) drive_beat(pk(15, 15, 15, 15), logic'(b == 4));
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b1 || out_sum !== 8'd44 || out_overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL over_packet: valid=%0b sum=%0d ovf=%0b, required 1/44/1",
               out_valid, out_sum, out_overflow);
    end
    // The overflow flag must not leak into the following packet.
    drive_beat(pk(1, 0, 0, 0), 1'b1);
    @(negedge clk);
    tests_run++;
    if (out_sum !== 8'd1 || out_overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_cleared: sum=%0d ovf=%0b, required 1/0", out_sum, out_overflow);
    end
  endtask

  task automatic test_backpressure();
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    drive_beat(pk(10, 10, 0, 0), 1'b1);
    @(negedge clk);
    drive_beat(pk(1, 2, 3, 4), 1'b1);
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 8'd20) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: ready=%0b valid=%0b sum=%0d, required 0/1/20",
                 i, in_ready, out_valid, out_sum);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || out_sum !== 8'd10 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_swap: valid=%0b sum=%0d ready=%0b, required 1/10/1",
               out_valid, out_sum, in_ready);
    end
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b1 || out_sum !== 8'd10) begin
      tests_failed++;
      $display("FAIL bp_stable: valid=%0b sum=%0d, required 1/10", out_valid, out_sum);
    end
    out_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_drain: valid=%0b, required 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    drv_done = 1'b0;
    mon_en   = 1'b1;
    fork
      begin
        for (int p = 0; p < 1000; p++) begin
          logic [N*W-1:0] beats [6];
          int   nb;
          exp_t e;
          nb = $urandom_range(1, 4);
          if ($urandom_range(0, 29) == 0) nb = $urandom_range(5, 6);
          e.sum = 0;
          for (int b = 0; b < nb; b++) begin
            beats[b] = N*W'($urandom_range(0, 65535));
            for (int k = 0; k < N; k++) e.sum += (beats[b] >> (k*W)) & 'hF;
          end
          e.sum = e.sum % 256;
          e.ovf = (nb > MB);
          exp_q.push_back(e);
          for (int b = 0; b < nb; b++) begin
            if ($urandom_range(0, 3) == 0) begin
              // Idle gap with junk on the data lines, which must be ignored.
              in_data = N*W'($urandom_range(0, 65535));
              in_last = logic'($urandom_range(0, 1));
              repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            drive_beat(beats[b], logic'(b == nb - 1));
          end
        end
        drv_done = 1'b1;
      end
      begin
        while (!(drv_done && exp_q.size() == 0) && cyc < 20000) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
          cyc++;
        end
      end
    join
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL stream_lost: %0d results outstanding, required 0", exp_q.size());
    end
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    mon_en = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL stream_idle: valid=%0b, required 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_packet();
    out_ready = 1'b0;
    drive_beat(pk(3, 3, 3, 3), 1'b1);
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b1 || out_sum !== 8'd12) begin
      tests_failed++;
      $display("FAIL rst_prior_held: valid=%0b sum=%0d, required 1/12", out_valid, out_sum);
    end
    drive_beat(pk(15, 15, 0, 0), 1'b0);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_sum !== 8'd0 || out_overflow !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid: valid=%0b sum=%0d ovf=%0b ready=%0b, required 0/0/0/1",
               out_valid, out_sum, out_overflow, in_ready);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    drive_beat(pk(1, 1, 1, 1), 1'b1);
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b1 || out_sum !== 8'd4 || out_overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_next_packet: valid=%0b sum=%0d ovf=%0b, required 1/4/0",
               out_valid, out_sum, out_overflow);
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_two_beat();
    test_max_packet();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_packet();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
